// File: rtl/pc_pkg.sv
// Shared constants and next-PC source encoding for the program-counter unit.
package pc_pkg;

    localparam int INSN_BYTES = 4;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_REG,
        SEL_RAS,
        SEL_EXC,
        SEL_HOLD
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][ADDR_W-1:0] mem;
    logic [PW-1:0]                ptr;
    logic [PW-1:0]                top_idx;
    logic [PW:0]                  count;
    logic                         do_pop;

    // ptr is the next free slot; once the stack wraps it also marks the oldest entry
    assign top_idx = ptr - PW'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && do_pop) begin
            mem[top_idx] <= din;
        end else if (push) begin
            mem[ptr] <= din;
            ptr      <= ptr + PW'(1);
            if (!full) count <= count + (PW+1)'(1);
        end else if (do_pop) begin
            ptr   <= top_idx;
            count <= count - (PW+1)'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with branch, register-indirect, RAS-return and exception redirect.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC   = 'h180,
    parameter int              RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              exc_req,
    input  logic [ADDR_W-1:0] imm_offset,
    input  logic              branch,
    input  logic              zero,
    input  logic              uncond_branch,
    input  logic              link,
    input  logic              ret,
    input  logic              use_reg_target,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] link_addr,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              misalign
);

    pc_sel_e           sel;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] reg_tgt;
    logic [ADDR_W-1:0] ras_top;
    logic              taken;
    logic              ras_push;
    logic              ras_pop;
    logic              mis_nxt;

    assign pc_plus4  = pc + ADDR_W'(INSN_BYTES);
    assign link_addr = pc_plus4;
    assign br_tgt    = pc + (imm_offset << 2);
    assign reg_tgt   = {reg_target[ADDR_W-1:2], 2'b00};
    assign taken     = (branch & zero) | uncond_branch;

    // RAS only moves on cycles that actually advance the PC
    assign ras_push = uncond_branch & link & ~stall & ~exc_req;
    assign ras_pop  = ret & ~ras_empty & ~stall & ~exc_req;

    pc_ras #(.ADDR_W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_plus4),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    always_comb begin
        sel = SEL_SEQ;
        if (exc_req)             sel = SEL_EXC;
        else if (stall)          sel = SEL_HOLD;
        else if (ret)            sel = ras_empty ? SEL_REG : SEL_RAS;
        else if (use_reg_target) sel = SEL_REG;
        else if (taken)          sel = SEL_BRANCH;
    end

    always_comb begin
        pc_nxt  = pc;
        mis_nxt = 1'b0;
        case (sel)
            SEL_SEQ:    pc_nxt = pc_plus4;
            SEL_BRANCH: pc_nxt = br_tgt;
            SEL_REG: begin
                pc_nxt  = reg_tgt;
                mis_nxt = (reg_target[1:0] != 2'b00);
            end
            SEL_RAS:    pc_nxt = ras_top;
            SEL_EXC:    pc_nxt = EXC_VEC;
            SEL_HOLD: begin
                pc_nxt  = pc;
                mis_nxt = misalign;
            end
            default:    pc_nxt = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_VEC;
            misalign <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            misalign <= mis_nxt;
        end
    end

endmodule
